updown_pulse_gen: RTL and testbench
===================================

// Module: updown_pulse_gen
// PURPOSE
// - Turns two raw, bouncing, active-low push buttons (UP, DOWN) into clean single-cycle
//   increase/decrease pulses, with optional hold-to-auto-repeat.
// - Sits directly upstream of the saturating up/down register. It drives that register's
//   increase/decrease inputs on the same clk.
// - Guarantees increase and decrease are never high in the same cycle.
// PARAMETERS
// - DEBOUNCE_CYCLES  default 50000    consecutive cycles a synced input must differ from stable state before it flips
// - HOLD_CYCLES      default 25000000 cycles a single press is held before the first auto-repeat pulse
// - REPEAT_CYCLES    default 5000000  cycles between auto-repeat pulses after the first one
// - REPEAT_EN        default 1        1 = auto-repeat enabled; 0 = exactly one pulse per press
// PORTS
// - clk            in   1  system clock, all logic on rising edge
// - reset          in   1  asynchronous, active-high reset
// - btn_up_n       in   1  raw UP button, active-low, asynchronous to clk
// - btn_down_n     in   1  raw DOWN button, active-low, asynchronous to clk
// - increase       out  1  one-cycle pulse requesting +1 (registered)
// - decrease       out  1  one-cycle pulse requesting -1 (registered)
// - repeat_active  out  1  high while in REPEAT state (registered)
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, FSM=IDLE, all counters 0,
//   sync flops and stable states = 1 (released).
// - Sync: 2-FF synchronizer per button. Nothing downstream samples the raw pins.
// - Debounce (per button):
//   - cnt increments while sync != stable; cnt clears on any cycle where sync == stable.
//   - stable flips when sync has differed for DEBOUNCE_CYCLES consecutive cycles; cnt clears.
//   - cnt width = $clog2(DEBOUNCE_CYCLES+1).
// - Press event = stable 1->0 (registered edge detect). Release = stable 0->1.
// - Latency: raw clean press to pulse = DEBOUNCE_CYCLES+3 rising edges
//   (2 sync + DEBOUNCE_CYCLES + 1 output register).
// - FSM states IDLE, HOLD, REPEAT, LOCK. Timer t is shared, width = $clog2(max(HOLD,REPEAT)+1).
//   - IDLE:
//     - press on exactly one button, other released -> pulse that direction, store dir, t=0, HOLD.
//     - both pressed (simultaneous or already held) -> LOCK, no pulse.
//   - HOLD:
//     - dir button released -> IDLE.
//     - other button pressed -> LOCK.
//     - REPEAT_EN=1 and t==HOLD_CYCLES-1 -> pulse dir, t=0, REPEAT.
//     - REPEAT_EN=0: wait in HOLD; t frozen at 0.
//   - REPEAT:
//     - dir released -> IDLE.
//     - other pressed -> LOCK.
//     - t==REPEAT_CYCLES-1 -> pulse dir, t=0.
//     - repeat_active=1 only in this state.
//   - LOCK: no pulses; -> IDLE only when both stable states are released.
// - Release and other-press are evaluated before timer expiry in the same cycle: no pulse is
//   emitted on the cycle a release/other-press is seen.
// - Pulses are exactly 1 cycle wide. increase & decrease == 0 in every cycle.
// - Reset mid-operation: outputs drop to 0 asynchronously. A button still held at reset
//   release yields one fresh press event after DEBOUNCE_CYCLES+3 edges.
// - Saturation is not this block's concern; pulses are issued regardless of downstream value.
// STRUCTURE
// - Shared header: FSM state encodings (2-bit: IDLE=0, HOLD=1, REPEAT=2, LOCK=3) and the
//   direction encoding (UP=0, DOWN=1).
// - One sub-module, btn_debounce (synchronizer + debounce counter + press/release edge
//   outputs), instantiated once per button. FSM, timer and output registers live in
//   updown_pulse_gen.
// TESTING (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3 unless noted)
// 1 Clean press: btn_up_n 1->0 at edge 0, held 5 cycles -> increase=1 only at edge 7,
//   decrease never high, repeat_active=0.
// 2 Bounce: btn_up_n toggles every 2 cycles for 12 cycles, then low for 20 cycles
//   -> exactly one increase pulse, 7 edges after the final settle.
// 3 Hold: btn_down_n low for 40 cycles -> decrease pulses at edges 7, 17, 20, 23, ...;
//   repeat_active=1 from edge 17 until release is debounced.
// 4 Lock: UP held, DOWN pressed 15 cycles later -> no pulses while both held. Release both,
//   then press DOWN alone -> one decrease; increase stays 0 throughout.
// 5 Reset mid-repeat: assert reset for 2 cycles in REPEAT with UP held -> increase and
//   repeat_active 0 immediately; one increase 7 edges after reset release.
// 6 REPEAT_EN=0: UP held 60 cycles -> exactly one increase pulse; repeat_active never 1.

Source files
------------

// File: rtl/updown_pulse_gen_pkg.sv
// Shared encodings for the up/down pulse generator: FSM states, pulse direction and debounce event bundle.
// No logic of its own; pure declarations.
package updown_pulse_gen_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;
    localparam logic [1:0] ST_LOCK   = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // held is the debounced level delayed to line up with the press/rel strobes
    typedef struct packed {
        logic held;
        logic press;
        logic rel;
    } btn_evt_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/updown_pulse_gen_btn_debounce.sv
// One button: 2-FF sync, debounce counter, registered press/release strobes.
// Latency: raw edge to strobe = DEBOUNCE_CYCLES+2 edges; no backpressure (strobes are single-cycle, never held).
module btn_debounce
    import updown_pulse_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     btn_n,
    output btn_evt_t evt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             stable_q, stable_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    always_comb begin
        sync_d   = {sync_q[0], btn_n};
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        prev_d  = stable_q;
        press_d = prev_q & ~stable_q;
        rel_d   = ~prev_q & stable_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            prev_q   <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
        end
    end

    assign evt.held  = ~prev_q;
    assign evt.press = press_q;
    assign evt.rel   = rel_q;

endmodule

// File: rtl/updown_pulse_gen.sv
// Two bouncing active-low buttons -> mutually exclusive single-cycle increase/decrease pulses with hold-to-repeat.
// Latency: raw press to pulse = DEBOUNCE_CYCLES+3 edges; no backpressure, downstream must accept every pulse.
module updown_pulse_gen
    import updown_pulse_gen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up_n,
    input  logic btn_down_n,
    output logic increase,
    output logic decrease,
    output logic repeat_active
);

    localparam int unsigned T_MAX = max_u(HOLD_CYCLES, REPEAT_CYCLES);
    localparam int T_W = $clog2(T_MAX + 1);
    localparam logic [T_W-1:0] HOLD_LAST   = T_W'(HOLD_CYCLES - 1);
    localparam logic [T_W-1:0] REPEAT_LAST = T_W'(REPEAT_CYCLES - 1);

    btn_evt_t up_evt, dn_evt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up_db (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_up_n),
        .evt   (up_evt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn_db (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_down_n),
        .evt   (dn_evt)
    );

    logic [1:0]     state_q, state_d;
    logic           dir_q, dir_d;
    logic [T_W-1:0] t_q, t_d;
    logic           increase_q, increase_d;
    logic           decrease_q, decrease_d;
    logic           repeat_active_q, repeat_active_d;
    logic           pulse, pulse_dir, dir_rel, oth_held;

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        t_d       = '0;
        pulse     = 1'b0;
        pulse_dir = dir_q;
        dir_rel   = (dir_q == DIR_UP) ? up_evt.rel  : dn_evt.rel;
        oth_held  = (dir_q == DIR_UP) ? dn_evt.held : up_evt.held;

        // release / other-press take priority over timer expiry in HOLD and REPEAT
        case (state_q)
            ST_IDLE: begin
                if (up_evt.held && dn_evt.held) begin
                    state_d = ST_LOCK;
                end else if (up_evt.press) begin
                    pulse     = 1'b1;
                    pulse_dir = DIR_UP;
                    dir_d     = DIR_UP;
                    state_d   = ST_HOLD;
                end else if (dn_evt.press) begin
                    pulse     = 1'b1;
                    pulse_dir = DIR_DOWN;
                    dir_d     = DIR_DOWN;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (dir_rel) begin
                    state_d = ST_IDLE;
                end else if (oth_held) begin
                    state_d = ST_LOCK;
                end else if (REPEAT_EN) begin
                    if (t_q == HOLD_LAST) begin
                        pulse   = 1'b1;
                        state_d = ST_REPEAT;
                    end else begin
                        t_d = t_q + T_W'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (dir_rel) begin
                    state_d = ST_IDLE;
                end else if (oth_held) begin
                    state_d = ST_LOCK;
                end else if (t_q == REPEAT_LAST) begin
                    pulse = 1'b1;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            ST_LOCK: begin
                if (!up_evt.held && !dn_evt.held) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        increase_d      = pulse && (pulse_dir == DIR_UP);
        decrease_d      = pulse && (pulse_dir == DIR_DOWN);
        repeat_active_d = (state_d == ST_REPEAT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            dir_q           <= DIR_UP;
            t_q             <= '0;
            increase_q      <= 1'b0;
            decrease_q      <= 1'b0;
            repeat_active_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            dir_q           <= dir_d;
            t_q             <= t_d;
            increase_q      <= increase_d;
            decrease_q      <= decrease_d;
            repeat_active_q <= repeat_active_d;
        end
    end

    assign increase      = increase_q;
    assign decrease      = decrease_q;
    assign repeat_active = repeat_active_q;

endmodule

// File: tb/tb_updown_pulse_gen.sv
// Bench for updown_pulse_gen: two instances (auto-repeat on/off) against an edge-indexed behavioural model.
module tb_updown_pulse_gen;

    localparam int D    = 4;
    localparam int H    = 10;
    localparam int R    = 3;
    localparam int MAXE = 4096;

    localparam int FREE       = 0;
    localparam int WAIT_FIRST = 1;
    localparam int AUTO       = 2;
    localparam int BLOCKED    = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_up_n = 1'b1;
    logic btn_down_n = 1'b1;
    logic inc0, dec0, rep0, inc1, dec1, rep1;

    always #5 clk = ~clk;

    updown_pulse_gen #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b1)) dut_rep (
        .clk(clk), .reset(reset), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
        .increase(inc0), .decrease(dec0), .repeat_active(rep0)
    );

    updown_pulse_gen #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1'b0)) dut_once (
        .clk(clk), .reset(reset), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
        .increase(inc1), .decrease(dec1), .repeat_active(rep1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model, indexed by rising edge since reset release
    bit raw_up[MAXE];
    bit raw_dn[MAXE];
    bit st_up[MAXE];
    bit st_dn[MAXE];
    int n = 0;
    int last_e = -1;
    int m_mode[2];
    int m_dir[2];
    int m_fire[2];
    bit e_inc[2], e_dec[2], e_rep[2];

    // synchronised value visible to the debouncer after edge k
    function automatic bit s_at(input bit up, input int k);
        if (k < 1) return 1'b1;
        return up ? raw_up[k-1] : raw_dn[k-1];
    endfunction

    function automatic bit st_at(input bit up, input int k);
        if (k < 0) return 1'b1;
        return up ? st_up[k] : st_dn[k];
    endfunction

    // stable flips at edge e when the last D synchronised samples all disagreed with it
    function automatic bit debounced(input bit up, input int e);
        bit prev;
        prev = st_at(up, e - 1);
        for (int j = 1; j <= D; j++)
            if (s_at(up, e - j) == prev) return prev;
        return !prev;
    endfunction

    task automatic model_edge();
        int e;
        bit uL, dL, uP, dP;
        e = n;
        raw_up[e] = btn_up_n;
        raw_dn[e] = btn_down_n;
        st_up[e]  = debounced(1'b1, e);
        st_dn[e]  = debounced(1'b0, e);
        uL = !st_at(1'b1, e - 2);
        dL = !st_at(1'b0, e - 2);
        uP = st_at(1'b1, e - 3) && uL;
        dP = st_at(1'b0, e - 3) && dL;
        for (int k = 0; k < 2; k++) begin
            bit my_held, oth_held;
            e_inc[k] = 1'b0;
            e_dec[k] = 1'b0;
            my_held  = (m_dir[k] == 0) ? uL : dL;
            oth_held = (m_dir[k] == 0) ? dL : uL;
            case (m_mode[k])
                FREE: begin
                    if (uL && dL) m_mode[k] = BLOCKED;
                    else if (uP || dP) begin
                        m_dir[k]  = uP ? 0 : 1;
                        e_inc[k]  = uP;
                        e_dec[k]  = !uP;
                        m_fire[k] = e + H;
                        m_mode[k] = WAIT_FIRST;
                    end
                end
                WAIT_FIRST, AUTO: begin
                    if (!my_held) m_mode[k] = FREE;
                    else if (oth_held) m_mode[k] = BLOCKED;
                    else if (k == 0 && e == m_fire[k]) begin
                        e_inc[k]  = (m_dir[k] == 0);
                        e_dec[k]  = (m_dir[k] == 1);
                        m_fire[k] = e + R;
                        m_mode[k] = AUTO;
                    end
                end
                default: if (!uL && !dL) m_mode[k] = FREE;
            endcase
            e_rep[k] = (m_mode[k] == AUTO);
        end
        last_e = e;
        n = n + 1;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n = 0;
            last_e = -1;
            for (int k = 0; k < 2; k++) begin
                m_mode[k] = FREE;
                m_dir[k]  = 0;
                m_fire[k] = 0;
                e_inc[k]  = 1'b0;
                e_dec[k]  = 1'b0;
                e_rep[k]  = 1'b0;
            end
        end else begin
            model_edge();
        end
    end

    // ---------------- per-cycle compare and pulse logs
    int q_inc0[$], q_dec0[$], q_inc1[$], q_dec1[$];
    int rep_rise = -1;
    int rep_fall = -1;
    bit rep0_prev = 1'b0;
    bit rep1_seen = 1'b0;

    always @(negedge clk) begin
        chk("model_inc_rep", inc0, e_inc[0]);
        chk("model_dec_rep", dec0, e_dec[0]);
        chk("model_act_rep", rep0, e_rep[0]);
        chk("model_inc_once", inc1, e_inc[1]);
        chk("model_dec_once", dec1, e_dec[1]);
        chk("model_act_once", rep1, e_rep[1]);
        chk("exclusive", {31'd0, inc0 & dec0}, 0);
        if (inc0) q_inc0.push_back(last_e);
        if (dec0) q_dec0.push_back(last_e);
        if (inc1) q_inc1.push_back(last_e);
        if (dec1) q_dec1.push_back(last_e);
        if (rep0 && !rep0_prev && rep_rise < 0) rep_rise = last_e;
        if (!rep0 && rep0_prev && rep_fall < 0) rep_fall = last_e;
        if (rep1) rep1_seen = 1'b1;
        rep0_prev = rep0;
    end

    // ---------------- driver helpers (all driving at negedge + 1)
    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        q_inc0.delete();
        q_dec0.delete();
        q_inc1.delete();
        q_dec1.delete();
        rep_rise = -1;
        rep_fall = -1;
        rep1_seen = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_rst_inc"}, {inc1, inc0}, 0);
        chk({tag, "_rst_dec"}, {dec1, dec0}, 0);
        chk({tag, "_rst_act"}, {rep1, rep0}, 0);
        cyc(2);
        clear_logs();
        reset = 1'b0;
    endtask

    function automatic int rel_at(input int q[$], input int idx, input int e0);
        if (idx >= q.size()) return -1;
        return q[idx] - e0;
    endfunction

    int e0;
    int up_left, dn_left;

    initial begin
        cyc(1);
        chk("init_inc", inc0, 0);
        chk("init_act", rep0, 0);

        // 1: clean press held 5 cycles
        do_reset("t1");
        e0 = n;
        btn_up_n = 1'b0;
        cyc(5);
        btn_up_n = 1'b1;
        cyc(30);
        chk("t1_inc_count", q_inc0.size(), 1);
        chk("t1_inc_edge", rel_at(q_inc0, 0, e0), 7);
        chk("t1_dec_count", q_dec0.size(), 0);
        chk("t1_act_rise", rep_rise, -1);

        // 2: bounce every 2 cycles for 12 cycles, then settle low for 20
        do_reset("t2");
        e0 = n;
        for (int i = 0; i < 12; i++) begin
            btn_up_n = ((i / 2) % 2 == 1);
            cyc(1);
        end
        btn_up_n = 1'b0;
        cyc(20);
        btn_up_n = 1'b1;
        cyc(30);
        chk("t2_once_count", q_inc1.size(), 1);
        chk("t2_once_edge", rel_at(q_inc1, 0, e0 + 12), 7);
        chk("t2_rep_first_edge", rel_at(q_inc0, 0, e0 + 12), 7);

        // 3: hold DOWN for 40 cycles
        do_reset("t3");
        e0 = n;
        btn_down_n = 1'b0;
        cyc(40);
        btn_down_n = 1'b1;
        cyc(30);
        chk("t3_dec_count", q_dec0.size(), 11);
        chk("t3_dec_p0", rel_at(q_dec0, 0, e0), 7);
        chk("t3_dec_p1", rel_at(q_dec0, 1, e0), 17);
        chk("t3_dec_p2", rel_at(q_dec0, 2, e0), 20);
        chk("t3_dec_p3", rel_at(q_dec0, 3, e0), 23);
        chk("t3_dec_last", rel_at(q_dec0, 10, e0), 44);
        chk("t3_act_rise", rep_rise - e0, 17);
        chk("t3_act_fall", rep_fall - e0, 47);
        chk("t3_inc_count", q_inc0.size(), 0);
        chk("t3_once_count", q_dec1.size(), 1);

        // 4: UP held, DOWN joins 15 cycles later -> lock; then DOWN alone
        do_reset("t4");
        e0 = n;
        btn_up_n = 1'b0;
        cyc(15);
        btn_down_n = 1'b0;
        cyc(12);
        chk("t4_pre_lock_count", q_inc0.size(), 3);
        chk("t4_pre_lock_last", rel_at(q_inc0, 2, e0), 20);
        clear_logs();
        cyc(20);
        btn_up_n = 1'b1;
        btn_down_n = 1'b1;
        cyc(15);
        e0 = n;
        btn_down_n = 1'b0;
        cyc(8);
        btn_down_n = 1'b1;
        cyc(20);
        chk("t4_inc_count", q_inc0.size(), 0);
        chk("t4_dec_count", q_dec0.size(), 1);
        chk("t4_dec_edge", rel_at(q_dec0, 0, e0), 7);

        // 5: reset while repeating with UP held, right on a pulse cycle
        do_reset("t5a");
        btn_up_n = 1'b0;
        cyc(27);
        chk("t5_pre_inc", inc0, 1);
        chk("t5_pre_act", rep0, 1);
        do_reset("t5");
        e0 = n;
        cyc(8);
        btn_up_n = 1'b1;
        cyc(20);
        chk("t5_inc_count", q_inc0.size(), 1);
        chk("t5_inc_edge", rel_at(q_inc0, 0, e0), 7);

        // 6: single-pulse instance with a long hold
        do_reset("t6");
        e0 = n;
        btn_up_n = 1'b0;
        cyc(60);
        btn_up_n = 1'b1;
        cyc(20);
        chk("t6_once_count", q_inc1.size(), 1);
        chk("t6_once_edge", rel_at(q_inc1, 0, e0), 7);
        chk("t6_once_act", {31'd0, rep1_seen}, 0);

        // random: independent hold times per button, occasional reset
        do_reset("rnd");
        up_left = 0;
        dn_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (up_left == 0) begin
                btn_up_n = 1'($urandom_range(0, 1));
                up_left  = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 45);
            end
            if (dn_left == 0) begin
                btn_down_n = 1'($urandom_range(0, 1));
                dn_left    = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 45);
            end
            up_left--;
            dn_left--;
            if ($urandom_range(0, 499) == 0) do_reset("rnd_mid");
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
